seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 33 (`DATA_WIDTH + 1), operand/result width including the sign-extension bit.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port div_s1  input  WIDTH  dividend, two's complement, already sign- or zero-extended by the requester.
REQ-005 SHALL have port div_s2  input  WIDTH  divisor, same encoding as div_s1.
REQ-006 SHALL have port div_start  input  1  level request; sampled only in IDLE.
REQ-007 SHALL have port div_quotient  output  WIDTH  registered signed quotient.
REQ-008 SHALL have port div_remainder  output  WIDTH  registered signed remainder.
REQ-009 SHALL have port div_ready  output  1  single-cycle completion strobe; results are valid in that cycle.

Function
REQ-010 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE with div_start=1 and div_s2!=0, SHALL latch the operand magnitudes and signs, clear the iteration counter and partial remainder, and enter BUSY.
REQ-012 In IDLE with div_start=1 and div_s2==0, SHALL load quotient = all ones and remainder = div_s1, and enter DONE directly (latency 1).
REQ-013 In BUSY, SHALL perform one restoring shift-subtract step per cycle, MSB first, producing one quotient bit per cycle over exactly WIDTH cycles.
REQ-014 Magnitudes SHALL be computed as WIDTH-bit unsigned values; |-2^(WIDTH-1)| SHALL be representable without overflow.
REQ-015 On the BUSY-to-DONE transition, SHALL negate the quotient if sign(s1) XOR sign(s2) = 1, and SHALL negate the remainder if sign(s1) = 1.
REQ-016 SHALL assert div_ready=1 only in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-017 For a non-zero divisor, div_ready SHALL be high in the (WIDTH+1)th cycle after the IDLE cycle that sampled div_start.
REQ-018 SHALL ignore div_start in BUSY and DONE; a change in operand value during BUSY SHALL NOT affect the result.
REQ-019 A request held high through DONE SHALL be accepted again in the following IDLE cycle, so back-to-back divisions cost one idle cycle.
REQ-020 div_quotient and div_remainder SHALL hold their last result until the next completion.
REQ-021 The signed result of -2^31 / -1 SHALL be +2^31 in WIDTH bits; truncation to 32 bits is left to the requester.

Reset
REQ-022 On rst_n=0, SHALL asynchronously enter IDLE and clear div_quotient, div_remainder, div_ready, the counter and all datapath registers to 0.
REQ-023 Reset during BUSY SHALL abort the operation; div_ready SHALL NOT assert for the aborted request.
REQ-024 After reset release, the first div_start SHALL be accepted in the first IDLE cycle.

Structure
REQ-025 SHALL take DATA_WIDTH from the shared Define.v; the FSM state encodings and the counter width, $clog2(WIDTH+1), SHALL be local to the module.
REQ-026 SHALL contain no sub-module; the shift-subtract step SHALL be inline.
REQ-027 SHALL be a drop-in responder for the div_start / div_ready handshake of the M-extension wrapper.

Verification
REQ-028 Bench SHALL cover signed division: 100 / 7 -> quotient 14, remainder 2, with div_ready exactly 34 cycles after start.
REQ-029 Bench SHALL cover negative operands: -7 / 2 -> quotient -3, remainder -1; and 7 / -2 -> quotient -3, remainder 1.
REQ-030 Bench SHALL cover divide-by-zero: 0x1_2345_6789 / 0 -> quotient 0x1_FFFF_FFFF, remainder 0x1_2345_6789, with div_ready on the next cycle.
REQ-031 Bench SHALL cover overflow and unsigned cases: -2^31 / -1 -> quotient 0x0_8000_0000, remainder 0; zero-extended 0xFFFF_FFFF / 1 -> quotient 0x0_FFFF_FFFF.
REQ-032 Bench SHALL cover reset mid-operation: rst_n low at cycle 10 of BUSY -> no div_ready, outputs 0, and the next start completes correctly.
REQ-033 Bench SHALL cover request and operand changes while busy: operands and div_start toggled during BUSY are ignored, and a held start is re-accepted once after DONE.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: the datapath width of the core
// and the operand width (one extra bit for sign/zero extension by the requester).
package seq_divider_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DIV_WIDTH  = DATA_WIDTH + 1;

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 signed divider: one quotient bit per cycle over WIDTH cycles,
// divide-by-zero answered in a single cycle, results held until the next completion.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] div_s1,
    input  logic [WIDTH-1:0] div_s2,
    input  logic             div_start,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_ready,
    output logic [1:0]       dbg_state
);

    // Handshake: div_start is a level sampled only in IDLE; div_ready is a
    // one-cycle strobe and the results are valid in that cycle and held after.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] mag_s1;
    logic [WIDTH-1:0] mag_s2;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             step_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;

    always_comb begin
        // Unsigned WIDTH-bit magnitudes, so the most negative operand still fits.
        mag_s1 = div_s1[WIDTH-1] ? (~div_s1 + WIDTH'(1)) : div_s1;
        mag_s2 = div_s2[WIDTH-1] ? (~div_s2 + WIDTH'(1)) : div_s2;

        // The partial remainder stays below the divisor, so after the shift
        // only the compare needs the extra bit; the difference fits in WIDTH.
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        step_ge   = rem_shift >= {1'b0, dvs_q};
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
        rem_next  = step_ge ? rem_sub : rem_shift[WIDTH-1:0];
        dvd_next  = {dvd_q[WIDTH-2:0], step_ge};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
        ready_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    if (div_s2 == '0) begin
                        quot_d  = '1;
                        remd_d  = div_s1;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d      = mag_s1;
                        dvs_d      = mag_s2;
                        neg_quot_d = div_s1[WIDTH-1] ^ div_s2[WIDTH-1];
                        neg_rem_d  = div_s1[WIDTH-1];
                        cnt_d      = '0;
                        rem_d      = '0;
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                dvd_d = dvd_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    // Signs are applied while the final step lands in the output flops.
                    quot_d  = neg_quot_q ? (~dvd_next + WIDTH'(1)) : dvd_next;
                    remd_d  = neg_rem_q ? (~rem_next + WIDTH'(1)) : rem_next;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
            ready_q    <= ready_d;
        end
    end

    assign div_quotient  = quot_q;
    assign div_remainder = remd_q;
    assign div_ready     = ready_q;
    assign dbg_state     = state_q;

endmodule
